// File: rtl/mem_responder.sv
// Memory-bus target: byte RAM with one-cycle read latency plus a small I/O block
// (TX byte FIFO with near-full back-pressure, RX byte port, sticky halt register).
module mem_responder #(
    parameter int unsigned RAM_AW   = 17,
    parameter int unsigned TX_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rdy_i,
    input  logic        mem_enable_i,
    input  logic        read_write_i,
    input  logic [31:0] mem_addr_i,
    input  logic [7:0]  mem_byte_write_i,
    output logic [7:0]  mem_byte_read_o,
    output logic        io_buffer_full_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_pop_o,
    output logic        halt_o,
    output logic        tx_overflow_o
);

    localparam int unsigned PtrW = $clog2(TX_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC    = CntW'(TX_DEPTH);
    localparam logic [CntW-1:0] NearFullC = CntW'(TX_DEPTH - 1);

    logic [7:0]      ram_q [2**RAM_AW];
    logic [7:0]      fifo_q [TX_DEPTH];

    logic [7:0]      rd_data_q, rd_data_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q, full_d;
    logic            rx_pop_q, rx_pop_d;
    logic            halt_q, halt_d;
    logic            ovf_q, ovf_d;

    logic              req, is_io;
    logic [2:0]        reg_sel;
    logic              ram_we, io_wr0;
    logic              tx_pop, tx_push;
    logic [RAM_AW-1:0] ram_addr;

    // Request decode; rdy gates every side effect.
    always_comb begin
        req      = rdy_i & mem_enable_i;
        is_io    = (mem_addr_i[17:16] == 2'b11);
        reg_sel  = mem_addr_i[2:0];
        ram_addr = mem_addr_i[RAM_AW-1:0];
        ram_we   = req & ~is_io & read_write_i;
        io_wr0   = req & is_io & read_write_i & (reg_sel == 3'd0);
        tx_pop   = tx_valid_o & tx_ready_i & rdy_i;
        // A same-cycle pop frees a slot, so a push at full is still accepted.
        tx_push  = io_wr0 & ((count_q < DepthC) | tx_pop);
    end

    // Next-state for read data, FIFO bookkeeping and the sticky flags.
    always_comb begin
        rd_data_d = rd_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rx_pop_d  = 1'b0;
        halt_d    = halt_q;
        ovf_d     = ovf_q;

        if (req && !read_write_i) begin
            if (!is_io) begin
                rd_data_d = ram_q[ram_addr];
            end else begin
                unique case (reg_sel)
                    3'd0: begin
                        rd_data_d = rx_valid_i ? rx_data_i : 8'h00;
                        rx_pop_d  = rx_valid_i;
                    end
                    3'd4:    rd_data_d = {6'b0, rx_valid_i, count_q == DepthC};
                    default: rd_data_d = 8'h00;
                endcase
            end
        end

        if (req && is_io && read_write_i && reg_sel == 3'd4) begin
            halt_d = 1'b1;
        end
        if (io_wr0 && !tx_push) begin
            ovf_d = 1'b1;
        end

        if (tx_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (tx_push && !tx_pop) begin
            count_d = count_q + 1'b1;
        end else if (tx_pop && !tx_push) begin
            count_d = count_q - 1'b1;
        end

        full_d = (count_d >= NearFullC);
    end

    // Control/status registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_q <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            rx_pop_q  <= 1'b0;
            halt_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            rx_pop_q  <= rx_pop_d;
            halt_q    <= halt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage arrays are not reset; writes are blocked while in reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && ram_we) begin
            ram_q[ram_addr] <= mem_byte_write_i;
        end
        if (rst_ni && tx_push) begin
            fifo_q[wr_ptr_q] <= mem_byte_write_i;
        end
    end

    // Outputs come straight from state; head byte is masked to zero when empty.
    always_comb begin
        mem_byte_read_o  = rd_data_q;
        io_buffer_full_o = full_q;
        tx_valid_o       = (count_q != '0);
        tx_data_o        = tx_valid_o ? fifo_q[rd_ptr_q] : 8'h00;
        rx_pop_o         = rx_pop_q;
        halt_o           = halt_q;
        tx_overflow_o    = ovf_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a queue/array reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n, rdy, mem_enable, read_write, tx_ready, rx_valid;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, rx_data;
    logic [7:0]  mem_rdata, tx_data;
    logic        io_full, tx_valid, rx_pop, halt, tx_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .rdy_i            (rdy),
        .mem_enable_i     (mem_enable),
        .read_write_i     (read_write),
        .mem_addr_i       (mem_addr),
        .mem_byte_write_i (mem_wdata),
        .mem_byte_read_o  (mem_rdata),
        .io_buffer_full_o (io_full),
        .tx_data_o        (tx_data),
        .tx_valid_o       (tx_valid),
        .tx_ready_i       (tx_ready),
        .rx_data_i        (rx_data),
        .rx_valid_i       (rx_valid),
        .rx_pop_o         (rx_pop),
        .halt_o           (halt),
        .tx_overflow_o    (tx_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: RAM as an associative array, FIFO as a queue.
    logic [7:0] ram_m [int];
    logic [7:0] q_m [$];
    logic [7:0] rd_m;
    bit         rd_known, rxpop_m, halt_m, ovf_m, model_on;

    always @(posedge clk) begin
        if (!rst_n) begin
            q_m.delete();
            rd_m = 8'h00; rd_known = 1'b1;
            rxpop_m = 1'b0; halt_m = 1'b0; ovf_m = 1'b0;
            model_on = 1'b1;
        end else if (rdy) begin
            bit pop, push, io;
            int a;
            pop = (q_m.size() > 0) && tx_ready;
            push = 1'b0;
            rxpop_m = 1'b0;
            io = (mem_addr[17:16] == 2'b11);
            a = int'(mem_addr[16:0]);
            if (mem_enable) begin
                if (!io && read_write) begin
                    ram_m[a] = mem_wdata;
                end else if (!io) begin
                    rd_known = ram_m.exists(a);
                    if (rd_known) rd_m = ram_m[a];
                end else if (!read_write) begin
                    rd_known = 1'b1;
                    if (mem_addr[2:0] == 3'd0) begin
                        rd_m = rx_valid ? rx_data : 8'h00;
                        rxpop_m = rx_valid;
                    end else if (mem_addr[2:0] == 3'd4) begin
                        rd_m = {6'b0, rx_valid, q_m.size() == 8};
                    end else begin
                        rd_m = 8'h00;
                    end
                end else if (mem_addr[2:0] == 3'd0) begin
                    if (q_m.size() < 8 || pop) push = 1'b1;
                    else ovf_m = 1'b1;
                end else if (mem_addr[2:0] == 3'd4) begin
                    halt_m = 1'b1;
                end
            end
            if (pop) void'(q_m.pop_front());
            if (push) q_m.push_back(mem_wdata);
        end else begin
            rxpop_m = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            if (rd_known) chk("model_rdata", mem_rdata, rd_m);
            chk("model_tx_valid", tx_valid, q_m.size() > 0);
            chk("model_tx_data", tx_data, (q_m.size() > 0) ? q_m[0] : 8'h00);
            chk("model_io_full", io_full, q_m.size() >= 7);
            chk("model_rx_pop", rx_pop, rxpop_m);
            chk("model_halt", halt, halt_m);
            chk("model_overflow", tx_ovf, ovf_m);
        end
    end

    task automatic step(input logic en, input logic rw, input logic [31:0] a,
                        input logic [7:0] d);
        mem_enable = en; read_write = rw; mem_addr = a; mem_wdata = d;
        @(negedge clk);
    endtask

    logic [7:0] drain [8];

    initial begin
        rst_n = 1'b0; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        step(1'b0, 1'b0, 32'h0, 8'h00);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        rst_n = 1'b1;
        chk("reset_rdata", mem_rdata, 8'h00);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_halt", halt, 1'b0);

        // 1: write then read, one-cycle latency, no write-through
        step(1'b1, 1'b1, 32'h100, 8'h55);
        chk("t1_no_write_through", mem_rdata, 8'h00);
        step(1'b1, 1'b0, 32'h100, 8'h00);
        chk("t1_read_55", mem_rdata, 8'h55);

        // 2: back-to-back reads
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(i), 8'(8'h11 * (i + 1)));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'(i), 8'h00);
            chk("t2_b2b_read", mem_rdata, 8'(8'h11 * (i + 1)));
        end

        // 3: fill FIFO, near-full, overflow
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 32'h30000, 8'(8'hA0 + i));
            if (i == 5) chk("t3_not_full_6", io_full, 1'b0);
            if (i == 6) chk("t3_full_7", io_full, 1'b1);
            if (i == 7) chk("t3_no_ovf_8", tx_ovf, 1'b0);
            if (i == 8) chk("t3_ovf_9", tx_ovf, 1'b1);
        end
        step(1'b1, 1'b0, 32'h30004, 8'h00);
        chk("t3_status_full", mem_rdata, 8'h01);

        // 4: push+pop at count 8 across the pointer wrap
        tx_ready = 1'b1;
        step(1'b1, 1'b1, 32'h30000, 8'hB0);
        tx_ready = 1'b0;
        chk("t4_head_a1", tx_data, 8'hA1);
        chk("t4_still_full", io_full, 1'b1);
        step(1'b1, 1'b0, 32'h30004, 8'h00);
        chk("t4_count_8", mem_rdata, 8'h01);
        drain = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hB0};
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_drain_order", tx_data, drain[i]);
            step(1'b0, 1'b0, 32'h0, 8'h00);
        end
        tx_ready = 1'b0;
        chk("t4_empty_valid", tx_valid, 1'b0);
        chk("t4_empty_data", tx_data, 8'h00);

        // 5: RX port
        rx_valid = 1'b1; rx_data = 8'h41;
        step(1'b1, 1'b0, 32'h30000, 8'h00);
        chk("t5_rx_data", mem_rdata, 8'h41);
        chk("t5_rx_pop", rx_pop, 1'b1);
        rx_valid = 1'b0;
        step(1'b0, 1'b0, 32'h0, 8'h00);
        chk("t5_pop_one_cycle", rx_pop, 1'b0);
        step(1'b1, 1'b0, 32'h30000, 8'h00);
        chk("t5_rx_empty", mem_rdata, 8'h00);
        chk("t5_no_pop", rx_pop, 1'b0);
        rx_valid = 1'b1;
        step(1'b1, 1'b0, 32'h30004, 8'h00);
        chk("t5_status_rx", mem_rdata, 8'h02);
        rx_valid = 1'b0;

        // 6: halt, rdy freeze, mid-stream reset
        step(1'b1, 1'b1, 32'h30004, 8'h00);
        chk("t6_halt", halt, 1'b1);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        chk("t6_halt_sticky", halt, 1'b1);
        rdy = 1'b0;
        step(1'b1, 1'b1, 32'h100, 8'h99);
        step(1'b1, 1'b0, 32'h100, 8'h00);
        chk("t6_rdy_hold", mem_rdata, 8'h02);
        rdy = 1'b1;
        step(1'b1, 1'b0, 32'h100, 8'h00);
        chk("t6_ram_unchanged", mem_rdata, 8'h55);
        step(1'b1, 1'b1, 32'h30000, 8'hC1);
        step(1'b1, 1'b1, 32'h30000, 8'hC2);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 32'h100, 8'h00);
        chk("t6_rst_rdata", mem_rdata, 8'h00);
        chk("t6_rst_tx_valid", tx_valid, 1'b0);
        chk("t6_rst_tx_data", tx_data, 8'h00);
        chk("t6_rst_halt", halt, 1'b0);
        chk("t6_rst_full", io_full, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, 8'h00);
        chk("t6_no_replay", mem_rdata, 8'h00);

        step(1'b0, 1'b0, 32'h0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
